// File: rtl/time_pkg.sv
// Shared types and constants for the BCD time-of-day to seconds-of-day packer.
package time_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ACC
    } state_e;

    // Six BCD digits of HH:MM:SS, most significant digit first.
    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h2;
        logic [3:0] m1;
        logic [3:0] m2;
        logic [3:0] s1;
        logic [3:0] s2;
    } bcd_time_t;

    localparam int SEC_PER_DAY = 86400;
    localparam int RADIX_TEN   = 10;
    localparam int RADIX_SIX   = 6;
    localparam int NUM_STEPS   = 5;

endpackage

// File: rtl/time_pack_check.sv
// Combinational HH:MM:SS BCD validator; shared with the manual-set input path.
module bcd_time_check
    import time_pkg::*;
#(
    parameter int HOUR_LIMIT = 24
) (
    input  logic [3:0] h1,
    input  logic [3:0] h2,
    input  logic [3:0] m1,
    input  logic [3:0] m2,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    output logic       valid
);

    logic [7:0] hours;
    logic       digits_ok;

    // Hours value 10*h1 + h2 via shift-add; 8 bits covers any nibble pair.
    assign hours = ({4'b0, h1} << 3) + ({4'b0, h1} << 1) + {4'b0, h2};

    assign digits_ok = (h1 <= 4'd9) && (h2 <= 4'd9) &&
                       (m1 <= 4'd5) && (m2 <= 4'd9) &&
                       (s1 <= 4'd5) && (s2 <= 4'd9);

    assign valid = digits_ok && (int'(hours) < HOUR_LIMIT);

endmodule

// File: rtl/time_pack.sv
// Converts captured HH:MM:SS BCD digits to a seconds-of-day count by
// mixed-radix Horner accumulation, one digit per cycle, shift-add only.
module time_pack
    import time_pkg::*;
#(
    parameter int SEC_W      = 17,
    parameter int HOUR_LIMIT = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       h1,
    input  logic [3:0]       h2,
    input  logic [3:0]       m1,
    input  logic [3:0]       m2,
    input  logic [3:0]       s1,
    input  logic [3:0]       s2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SEC_W-1:0] seconds
);

    if ((2 ** SEC_W) < SEC_PER_DAY) begin : g_width_check
        $error("SEC_W too narrow for a full day of seconds");
    end

    state_e           state_q, state_d;
    bcd_time_t        dig_q;
    logic             cap_en;
    logic [SEC_W-1:0] acc_q, acc_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [2:0]       step_q, step_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             valid;
    logic [3:0]       radix;
    logic [3:0]       digit;
    logic [SEC_W-1:0] scaled;
    logic [SEC_W-1:0] acc_next;

    bcd_time_check #(
        .HOUR_LIMIT(HOUR_LIMIT)
    ) u_check (
        .h1   (dig_q.h1),
        .h2   (dig_q.h2),
        .m1   (dig_q.m1),
        .m2   (dig_q.m2),
        .s1   (dig_q.s1),
        .s2   (dig_q.s2),
        .valid(valid)
    );

    // Horner step: step_q selects the radix and the digit folded in this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        radix = 4'(RADIX_TEN);
        digit = 4'd0;
        case (step_q)
            3'd1: begin radix = 4'(RADIX_TEN); digit = dig_q.h2; end
            3'd2: begin radix = 4'(RADIX_SIX); digit = dig_q.m1; end
            3'd3: begin radix = 4'(RADIX_TEN); digit = dig_q.m2; end
            3'd4: begin radix = 4'(RADIX_SIX); digit = dig_q.s1; end
            3'd5: begin radix = 4'(RADIX_TEN); digit = dig_q.s2; end
            default: ;
        endcase
        scaled = (radix == 4'(RADIX_SIX)) ? (acc_q << 2) + (acc_q << 1)
                                          : (acc_q << 3) + (acc_q << 1);
        acc_next = scaled + SEC_W'(digit);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        sec_d   = sec_q;
        err_d   = err_q;
        done_d  = 1'b0;
        cap_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cap_en  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!valid) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = SEC_W'(dig_q.h1);
                    step_d  = 3'd1;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (step_q == 3'(NUM_STEPS)) begin
                    sec_d   = acc_next;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    step_d  = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    acc_d  = acc_next;
                    step_d = step_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            step_q  <= 3'd0;
            sec_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            sec_q   <= sec_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: digit capture registers are deliberately unreset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            dig_q <= '{h1: h1, h2: h2, m1: m1, m2: m2, s1: s1, s2: s2};
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign seconds = sec_q;

endmodule

// File: tb/tb_time_pack.sv
// Self-checking bench for time_pack: directed vector table, multi-cycle corner
// sequences, and randomized digits checked against an arithmetic reference model.
module tb_time_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  h1, h2, m1, m2, s1, s2;
    logic        busy, done, err;
    logic [16:0] seconds;

    int n_checks = 0;
    int n_errors = 0;
    int model_sec = 0;

    typedef struct {
        logic [3:0] h1, h2, m1, m2, s1, s2;
        bit         exp_err;
        int         exp_sec;
    } vec_t;

    vec_t vecs[11];

    time_pack #(
        .SEC_W(17),
        .HOUR_LIMIT(24)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .h1     (h1),
        .h2     (h2),
        .m1     (m1),
        .m2     (m2),
        .s1     (s1),
        .s2     (s2),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .seconds(seconds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model works from the time-of-day rules, not from any datapath detail.
    function automatic bit ref_valid(int a, int b, int c, int d, int e, int f);
        return (a <= 9) && (b <= 9) && (a * 10 + b < 24) &&
               (c <= 5) && (d <= 9) && (e <= 5) && (f <= 9);
    endfunction

    function automatic int ref_secs(int a, int b, int c, int d, int e, int f);
        return (a * 10 + b) * 3600 + (c * 10 + d) * 60 + (e * 10 + f);
    endfunction

    function automatic logic [3:0] rdig(int maxv);
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, maxv));
    endfunction

    // Called mid-cycle; returns at #1 after the edge where done is seen, so a
    // following call issues its start in the done cycle (back-to-back).
    task automatic do_conv(input logic [3:0] a, b, c, d, e, f,
                           output int lat, output int busy_cnt);
        {h1, h2, m1, m2, s1, s2} = {a, b, c, d, e, f};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        {h1, h2, m1, m2, s1, s2} = 24'($urandom);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        int lat, bcnt, extra, edges;
        logic [3:0] a, b, c, d, e, f;
        bit v;

        vecs[0]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,  1'b0, 45296};
        vecs[1]  = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9,  1'b0, 86399};
        vecs[2]  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,  1'b0, 0};
        vecs[3]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,  1'b0, 45296};
        vecs[4]  = '{4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0,  1'b1, 45296};
        vecs[5]  = '{4'd1, 4'd2, 4'd6, 4'd0, 4'd0, 4'd0,  1'b1, 45296};
        vecs[6]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hA,  1'b1, 45296};
        vecs[7]  = '{4'hF, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,  1'b1, 45296};
        vecs[8]  = '{4'd0, 4'd7, 4'd0, 4'd8, 4'd0, 4'd9,  1'b0, 25689};
        vecs[9]  = '{4'd1, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0,  1'b1, 25689};
        vecs[10] = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,  1'b0, 72000};

        rst = 1'b1;
        start = 1'b0;
        {h1, h2, m1, m2, s1, s2} = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset err", int'(err), 0);
        check("reset seconds", int'(seconds), 0);

        // Directed table; consecutive entries also exercise start in the done cycle.
        foreach (vecs[i]) begin
            do_conv(vecs[i].h1, vecs[i].h2, vecs[i].m1, vecs[i].m2, vecs[i].s1, vecs[i].s2,
                    lat, bcnt);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_err ? 1 : 6);
            if (!vecs[i].exp_err) check($sformatf("vec%0d busy cycles", i), bcnt, 6);
            check($sformatf("vec%0d err", i), int'(err), int'(vecs[i].exp_err));
            check($sformatf("vec%0d seconds", i), int'(seconds), vecs[i].exp_sec);
            model_sec = vecs[i].exp_sec;
        end

        // Start while busy is ignored: one done, first request's value.
        {h1, h2, m1, m2, s1, s2} = {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        {h1, h2, m1, m2, s1, s2} = {4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 3;
        while (!done && edges < 20) begin @(posedge clk); #1; edges++; end
        check("busy-start latency", edges, 6);
        check("busy-start err", int'(err), 0);
        check("busy-start seconds", int'(seconds), 3600);
        model_sec = 3600;
        extra = 0;
        repeat (15) begin @(posedge clk); #1; if (done) extra++; end
        check("busy-start extra dones", extra, 0);

        // Sticky err, then reset during step3 abandons the conversion.
        do_conv(4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, lat, bcnt);
        check("pre-reset err", int'(err), 1);
        {h1, h2, m1, m2, s1, s2} = {4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("err held while busy", int'(err), 1);
        check("busy before reset", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid-reset busy", int'(busy), 0);
        check("mid-reset done", int'(done), 0);
        check("mid-reset err", int'(err), 0);
        check("mid-reset seconds", int'(seconds), 0);
        extra = 0;
        repeat (15) begin @(posedge clk); #1; if (done) extra++; end
        check("post-reset dones", extra, 0);
        do_conv(4'd0, 4'd0, 4'd0, 4'd1, 4'd4, 4'd0, lat, bcnt);
        check("after-reset latency", lat, 6);
        check("after-reset err", int'(err), 0);
        check("after-reset seconds", int'(seconds), 100);
        model_sec = 100;

        // Randomized digits against the reference model.
        for (int k = 0; k < 40; k++) begin
            a = rdig(2); b = rdig(9); c = rdig(5); d = rdig(9); e = rdig(5); f = rdig(9);
            v = ref_valid(int'(a), int'(b), int'(c), int'(d), int'(e), int'(f));
            if (v) model_sec = ref_secs(int'(a), int'(b), int'(c), int'(d), int'(e), int'(f));
            do_conv(a, b, c, d, e, f, lat, bcnt);
            check($sformatf("rand%0d latency", k), lat, v ? 6 : 1);
            check($sformatf("rand%0d err", k), int'(err), v ? 0 : 1);
            check($sformatf("rand%0d seconds", k), int'(seconds), model_sec);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
